// File: rtl/vga_sync_ctrl_pkg.sv
// Shared types and default timing for the VGA sync controller.
// Phase enum, 640x480@60 constants and a total-length helper.
package vga_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int vga_total(
        input int act,
        input int fp,
        input int sync,
        input int bp
    );
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// Timing bundle between the sync controller and the pixel stage.
// master: drives scan position/strobes, takes en. slave: the reverse.
interface vga_sync_if #(
    parameter int WIDTH = 10
);
    logic             en;
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] vcnt;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             line_end;
    logic             frame_end;
    logic             frame_start;

    modport master (
        input  en,
        output hcnt, vcnt, hsync, vsync,
        output video_on, line_end,
        output frame_end, frame_start
    );

    modport slave (
        output en,
        input  hcnt, vcnt, hsync, vsync,
        input  video_on, line_end,
        input  frame_end, frame_start
    );
endinterface

// File: rtl/vga_axis_fsm.sv
// One scan axis: ACTIVE->FP->SYNC->BP phase FSM plus absolute position.
// Ports: pclk, rst, step in; pos, last, phase_nxt, last_nxt out.
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int WIDTH  = 10
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] pos,
    output logic             last,
    output phase_t           phase_nxt,
    output logic             last_nxt
);
    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);
    localparam logic [WIDTH-1:0] LAST_POS = WIDTH'(TOTAL - 1);

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [WIDTH-1:0] r_pos;
    logic [WIDTH-1:0] w_pos_nxt;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] w_left_nxt;

    // Steps remaining in a phase after the entry step.
    function automatic logic [WIDTH-1:0] len_m1(input phase_t p);
        logic [WIDTH-1:0] v;
        v = WIDTH'(ACTIVE - 1);
        unique case (p)
            PH_ACTIVE: v = WIDTH'(ACTIVE - 1);
            PH_FP:     v = WIDTH'(FP - 1);
            PH_SYNC:   v = WIDTH'(SYNC - 1);
            PH_BP:     v = WIDTH'(BP - 1);
        endcase
        return v;
    endfunction

    always_comb begin
        w_phase_nxt = r_phase;
        w_pos_nxt   = r_pos;
        w_left_nxt  = r_left;
        if (step) begin
            if (r_left == '0) begin
                unique case (r_phase)
                    PH_ACTIVE: w_phase_nxt = PH_FP;
                    PH_FP:     w_phase_nxt = PH_SYNC;
                    PH_SYNC:   w_phase_nxt = PH_BP;
                    PH_BP:     w_phase_nxt = PH_ACTIVE;
                endcase
                w_left_nxt = len_m1(w_phase_nxt);
                // Leaving BP is the end of the axis: wrap position.
                w_pos_nxt = (r_phase == PH_BP) ? '0 : r_pos + 1'b1;
            end else begin
                w_left_nxt = r_left - 1'b1;
                w_pos_nxt  = r_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_phase <= PH_ACTIVE;
            r_pos   <= '0;
            r_left  <= len_m1(PH_ACTIVE);
        end else begin
            r_phase <= w_phase_nxt;
            r_pos   <= w_pos_nxt;
            r_left  <= w_left_nxt;
        end
    end

    assign pos       = r_pos;
    assign last      = (r_pos == LAST_POS);
    assign phase_nxt = w_phase_nxt;
    assign last_nxt  = (w_pos_nxt == LAST_POS);

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA display timing controller: H/V axis FSMs and registered decode.
// Ports: pclk, rst; bus (master) carries en in, positions/syncs/strobes out.
module vga_sync_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int WIDTH    = 10
) (
    input  logic        pclk,
    input  logic        rst,
    vga_sync_if.master  bus
);
    logic [WIDTH-1:0] w_h_pos;
    logic [WIDTH-1:0] w_v_pos;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_h_last_nxt;
    logic             w_v_last_nxt;
    phase_t           w_h_ph_nxt;
    phase_t           w_v_ph_nxt;
    logic             w_v_step;

    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_line_end;
    logic r_frame_end;
    logic r_frame_start;

    assign w_v_step = bus.en & w_h_last;

    vga_axis_fsm #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
        .BP(H_BP), .WIDTH(WIDTH)
    ) u_h (
        .pclk(pclk), .rst(rst), .step(bus.en),
        .pos(w_h_pos), .last(w_h_last),
        .phase_nxt(w_h_ph_nxt), .last_nxt(w_h_last_nxt)
    );

    vga_axis_fsm #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
        .BP(V_BP), .WIDTH(WIDTH)
    ) u_v (
        .pclk(pclk), .rst(rst), .step(w_v_step),
        .pos(w_v_pos), .last(w_v_last),
        .phase_nxt(w_v_ph_nxt), .last_nxt(w_v_last_nxt)
    );

    // Decode from next state so outputs land on the same edge as positions.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_video_on    <= 1'b1;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (bus.en) begin
            r_hsync <= (w_h_ph_nxt == PH_SYNC) ? HS_POL : ~HS_POL;
            r_vsync <= (w_v_ph_nxt == PH_SYNC) ? VS_POL : ~VS_POL;
            r_video_on <= (w_h_ph_nxt == PH_ACTIVE) &&
                          (w_v_ph_nxt == PH_ACTIVE);
            r_line_end    <= w_h_last_nxt;
            r_frame_end   <= w_h_last_nxt & w_v_last_nxt;
            // Only a natural wrap out of the final pixel starts a frame.
            r_frame_start <= w_h_last & w_v_last;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign bus.hcnt        = w_h_pos;
    assign bus.vcnt        = w_v_pos;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.video_on    = r_video_on;
    assign bus.line_end    = r_line_end;
    assign bus.frame_end   = r_frame_end;
    assign bus.frame_start = r_frame_start;

endmodule
